// File: rtl/sdram_axi_master.sv
// sdram_axi_master: single-outstanding bridge from a simple request/stream port to an AXI4 master
module sdram_axi_master #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        done_valid,
  output logic        done_err,
  output logic        out_awvalid,
  input  logic        out_awready,
  output logic [31:0] out_awaddr,
  output logic [3:0]  out_awid,
  output logic [7:0]  out_awlen,
  output logic [2:0]  out_awsize,
  output logic [1:0]  out_awburst,
  output logic        out_wvalid,
  input  logic        out_wready,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_wstrb,
  output logic        out_wlast,
  input  logic        out_bvalid,
  output logic        out_bready,
  input  logic [1:0]  out_bresp,
  input  logic [3:0]  out_bid,
  output logic        out_arvalid,
  input  logic        out_arready,
  output logic [31:0] out_araddr,
  output logic [3:0]  out_arid,
  output logic [7:0]  out_arlen,
  output logic [2:0]  out_arsize,
  output logic [1:0]  out_arburst,
  input  logic        out_rvalid,
  output logic        out_rready,
  input  logic [31:0] out_rdata,
  input  logic [1:0]  out_rresp,
  input  logic        out_rlast,
  input  logic [3:0]  out_rid
);
  localparam logic [2:0] IDLE = 3'd0, AW = 3'd1, W = 3'd2, B = 3'd3, AR = 3'd4, R = 3'd5, DONE = 3'd6;
  logic [2:0]  state;
  logic [31:0] addr_q;
  logic [7:0]  len_q, cnt;
  logic        err;
  logic        in_w, in_r, at_last, hs_w, hs_r, r_bad;
  // Phase decode; every output is forced quiet while reset is held low
  always_comb begin
    in_w    = reset && state == W;
    in_r    = reset && state == R;
    at_last = cnt == len_q;
    hs_w    = in_w && wr_valid && out_wready;
    hs_r    = in_r && out_rvalid && rd_ready;
    r_bad   = out_rresp != 2'b00 || out_rid != AXI_ID || out_rlast != at_last;
  end
  assign req_ready   = reset && state == IDLE;
  assign out_awvalid = reset && state == AW;
  assign out_awaddr  = out_awvalid ? addr_q : '0;
  assign out_awlen   = out_awvalid ? len_q : '0;
  assign out_awid    = AXI_ID;
  assign out_awsize  = 3'b010;
  assign out_awburst = 2'b01;
  assign out_wvalid  = in_w && wr_valid;
  assign wr_ready    = in_w && out_wready;
  assign out_wdata   = in_w ? wr_data : '0;
  assign out_wstrb   = in_w ? wr_strb : '0;
  assign out_wlast   = in_w && at_last;
  assign out_bready  = reset && state == B;
  assign out_arvalid = reset && state == AR;
  assign out_araddr  = out_arvalid ? addr_q : '0;
  assign out_arlen   = out_arvalid ? len_q : '0;
  assign out_arid    = AXI_ID;
  assign out_arsize  = 3'b010;
  assign out_arburst = 2'b01;
  assign rd_valid    = in_r && out_rvalid;
  assign out_rready  = in_r && rd_ready;
  assign rd_data     = in_r ? out_rdata : '0;
  assign rd_last     = in_r && out_rlast;
  assign done_valid  = reset && state == DONE;
  assign done_err    = done_valid && err;
  // Transaction sequencer: accept, address, data beats, response, completion
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      addr_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q <= req_addr & ~32'h3;
          len_q  <= req_len;
          cnt    <= '0;
          err    <= 1'b0;
          state  <= req_write ? AW : AR;
        end
        AW: state <= out_awready ? W : AW;
        W: if (hs_w) begin
          cnt   <= cnt + 8'd1;
          state <= at_last ? B : W;
        end
        B: if (out_bvalid) begin
          err   <= err || out_bresp != 2'b00 || out_bid != AXI_ID;
          state <= DONE;
        end
        AR: state <= out_arready ? R : AR;
        R: if (hs_r) begin
          cnt   <= cnt + 8'd1;
          err   <= err || r_bad;
          state <= (out_rlast || at_last) ? DONE : R;
        end
        DONE: begin
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_axi_master.sv
// tb_sdram_axi_master: randomized bench with a transaction-level model of requester and AXI slave
module tb_sdram_axi_master;
  logic clock = 0, reset = 0;
  always #5 clock = ~clock;
  logic        req_valid = 0, req_ready, req_write = 0;
  logic [31:0] req_addr = 0;
  logic [7:0]  req_len = 0;
  logic        wr_valid = 0, wr_ready;
  logic [31:0] wr_data = 0;
  logic [3:0]  wr_strb = 0;
  logic        rd_valid, rd_ready = 0, rd_last;
  logic [31:0] rd_data;
  logic        done_valid, done_err;
  logic        out_awvalid, out_awready = 0;
  logic [31:0] out_awaddr;
  logic [3:0]  out_awid;
  logic [7:0]  out_awlen;
  logic [2:0]  out_awsize;
  logic [1:0]  out_awburst;
  logic        out_wvalid, out_wready = 0, out_wlast;
  logic [31:0] out_wdata;
  logic [3:0]  out_wstrb;
  logic        out_bvalid = 0, out_bready;
  logic [1:0]  out_bresp = 0;
  logic [3:0]  out_bid = 0;
  logic        out_arvalid, out_arready = 0;
  logic [31:0] out_araddr;
  logic [3:0]  out_arid;
  logic [7:0]  out_arlen;
  logic [2:0]  out_arsize;
  logic [1:0]  out_arburst;
  logic        out_rvalid = 0, out_rready, out_rlast = 0;
  logic [31:0] out_rdata = 0;
  logic [1:0]  out_rresp = 0;
  logic [3:0]  out_rid = 0;

  sdram_axi_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_err(done_err),
    .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awaddr(out_awaddr), .out_awid(out_awid),
    .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
    .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wlast(out_wlast),
    .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bresp(out_bresp), .out_bid(out_bid),
    .out_arvalid(out_arvalid), .out_arready(out_arready), .out_araddr(out_araddr), .out_arid(out_arid),
    .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
    .out_rvalid(out_rvalid), .out_rready(out_rready), .out_rdata(out_rdata), .out_rresp(out_rresp),
    .out_rlast(out_rlast), .out_rid(out_rid)
  );

  int pass_cnt = 0, total = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] rdf(input logic [31:0] a, input int i);
    return a ^ (32'(i) * 32'h9E3779B9) ^ 32'(i);
  endfunction

  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        cfg_rand = 0;
  logic [1:0]  cfg_bresp = 0;
  logic [3:0]  cfg_bid = 0, cfg_rid = 0;
  int          cfg_rlast_at = 0, cfg_rerr_at = 999;
  logic        active = 0, exp_write = 0, exp_err = 0, aw_done = 0, ar_done = 0, r_fin = 0;
  logic [31:0] exp_addr = 0, ar_addr = 0, last_awaddr = 0;
  int          exp_len = 0, exp_nb = 0, w_beat = 0, r_beat = 0, done_cnt = 0, wlast_cnt = 0;
  logic [7:0]  last_awlen = 0;
  logic        last_err = 0, last_rd_last = 0, w_win, r_win;
  logic        hs_req, hs_aw, hs_w, hs_wl, hs_b, hs_ar, hs_r, done_now;
  logic [31:0] cap_araddr;

  // Per-cycle compare against the transaction model, then advance the model and drive slave/requester
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("reset_quiet", {req_ready, wr_ready, rd_valid, rd_last, done_valid, done_err, out_awvalid,
                            out_wvalid, out_wlast, out_bready, out_arvalid, out_rready}, 0);
        chk("reset_data", {out_awaddr, out_araddr} | {out_wdata, rd_data}, 0);
        chk("reset_lens", {out_awlen, out_arlen, out_wstrb}, 0);
        chk("reset_consts", {out_awsize, out_awburst, out_arsize, out_arburst, out_awid, out_arid}, {3'b010, 2'b01, 3'b010, 2'b01, 8'h00});
      end else begin
        w_win = active && exp_write && aw_done && w_beat <= exp_len;
        r_win = active && !exp_write && ar_done && !r_fin;
        chk("req_ready", req_ready, !active);
        chk("done_err_gate", done_err && !done_valid, 0);
        if (out_awvalid) begin
          chk("awaddr", out_awaddr, exp_addr);
          chk("awlen", out_awlen, exp_len);
          chk("aw_consts", {out_awsize, out_awburst, out_awid}, {3'b010, 2'b01, 4'h0});
          last_awaddr = out_awaddr;
          last_awlen = out_awlen;
        end
        if (out_arvalid) begin
          chk("araddr", out_araddr, exp_addr);
          chk("arlen", out_arlen, exp_len);
          chk("ar_consts", {out_arsize, out_arburst, out_arid}, {3'b010, 2'b01, 4'h0});
        end
        if (!w_win) chk("w_quiet", {wr_ready, out_wvalid}, 0);
        else begin
          chk("w_pass", {out_wvalid, wr_ready}, {wr_valid, out_wready});
          if (out_wvalid) begin
            chk("wdata", out_wdata, wd[w_beat]);
            chk("wstrb", out_wstrb, ws[w_beat]);
            chk("wlast", out_wlast, w_beat == exp_len);
          end
        end
        if (!r_win) chk("r_quiet", {rd_valid, out_rready}, 0);
        else begin
          chk("r_pass", {rd_valid, out_rready}, {out_rvalid, rd_ready});
          if (rd_valid) begin
            chk("rd_data", rd_data, rdf(exp_addr, r_beat));
            chk("rd_last", rd_last, r_beat == cfg_rlast_at);
            if (rd_ready) last_rd_last = rd_last;
          end
        end
        if (done_valid) begin
          chk("done_active", active, 1);
          chk("done_err", done_err, exp_err);
          chk("beats", exp_write ? w_beat : r_beat, exp_write ? exp_len + 1 : exp_nb);
          last_err = done_err;
        end
      end
      hs_req = req_valid && req_ready;
      hs_aw = out_awvalid && out_awready;
      hs_w = out_wvalid && out_wready;
      hs_wl = hs_w && out_wlast;
      hs_b = out_bvalid && out_bready;
      hs_ar = out_arvalid && out_arready;
      cap_araddr = out_araddr;
      hs_r = out_rvalid && out_rready;
      done_now = done_valid;
      @(posedge clock);
      #1;
      if (!reset) begin
        active = 0; aw_done = 0; ar_done = 0; r_fin = 0; w_beat = 0; r_beat = 0;
        out_bvalid = 0; out_rvalid = 0;
      end else begin
        if (hs_req) begin
          active = 1; exp_write = req_write; exp_addr = req_addr & ~32'h3; exp_len = int'(req_len);
          aw_done = 0; ar_done = 0; r_fin = 0; w_beat = 0; r_beat = 0; req_valid = 0;
        end
        if (hs_aw) aw_done = 1;
        if (hs_ar) begin ar_done = 1; ar_addr = cap_araddr; end
        if (hs_b) out_bvalid = 0;
        if (hs_wl) wlast_cnt++;
        if (hs_w) begin
          w_beat++;
          if (w_beat == exp_len + 1) begin out_bvalid = 1; out_bresp = cfg_bresp; out_bid = cfg_bid; end
        end
        if (hs_r) begin
          if (r_beat == cfg_rlast_at || r_beat == exp_len) r_fin = 1;
          r_beat++;
        end
        if (done_now) begin active = 0; done_cnt++; end
        out_awready = cfg_rand ? ($urandom & 1) != 0 : 1'b1;
        out_wready = cfg_rand ? ($urandom & 1) != 0 : 1'b1;
        out_arready = cfg_rand ? ($urandom & 1) != 0 : 1'b1;
        rd_ready = cfg_rand ? ($urandom & 1) != 0 : 1'b1;
        wr_valid = cfg_rand ? ($urandom & 1) != 0 : 1'b1;
        wr_data = wd[w_beat % 256];
        wr_strb = ws[w_beat % 256];
        out_rvalid = active && !exp_write && ar_done && !r_fin && (cfg_rand ? ($urandom & 1) != 0 : 1'b1);
        out_rdata = rdf(ar_addr, r_beat);
        out_rlast = r_beat == cfg_rlast_at;
        out_rresp = r_beat == cfg_rerr_at ? 2'b10 : 2'b00;
        out_rid = cfg_rid;
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input int len, input logic rnd,
                       input logic [1:0] bresp, input logic [3:0] bid, input int rlast_at, input int rerr_at, input logic [3:0] rid);
    @(posedge clock);
    #2;
    for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
    cfg_rand = rnd; cfg_bresp = bresp; cfg_bid = bid; cfg_rlast_at = rlast_at; cfg_rerr_at = rerr_at; cfg_rid = rid;
    exp_nb = (rlast_at < len ? rlast_at : len) + 1;
    exp_err = wr ? (bresp != 0 || bid != 0) : (rerr_at < exp_nb || rid != 0 || rlast_at != len);
    wlast_cnt = 0;
    req_write = wr; req_addr = addr; req_len = 8'(len); req_valid = 1;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt, n = 0;
    while (done_cnt == d0 && n < 6000) begin @(posedge clock); #2; n++; end
    chk({name, "_completes"}, done_cnt != d0, 1);
    repeat (3) @(posedge clock);
    #2;
    chk({name, "_one_done"}, done_cnt, d0 + 1);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2 reset = 1;
    @(negedge clock);
    chk("req_ready_after_reset", req_ready, 1);
    issue(1, 32'h8000_0006, 3, 0, 0, 0, 0, 999, 0);
    wait_done("t_write4");
    chk("t_write4_awaddr", last_awaddr, 32'h8000_0004);
    chk("t_write4_awlen", last_awlen, 3);
    chk("t_write4_wlast_cnt", wlast_cnt, 1);
    chk("t_write4_beats", w_beat, 4);
    chk("t_write4_err", last_err, 0);
    issue(0, 32'h0000_1000, 0, 0, 0, 0, 0, 999, 0);
    wait_done("t_read1");
    chk("t_read1_beats", r_beat, 1);
    chk("t_read1_last", last_rd_last, 1);
    chk("t_read1_err", last_err, 0);
    issue(0, 32'h1234_5678, 255, 1, 0, 0, 255, 999, 0);
    wait_done("t_read256");
    chk("t_read256_beats", r_beat, 256);
    chk("t_read256_err", last_err, 0);
    issue(1, 32'h0000_0040, 1, 0, 2'b10, 0, 0, 999, 0);
    wait_done("t_bresp");
    chk("t_bresp_err", last_err, 1);
    issue(1, 32'h0000_0080, 1, 0, 0, 0, 0, 999, 0);
    wait_done("t_after_err");
    chk("t_after_err_err", last_err, 0);
    issue(0, 32'h0000_0100, 3, 0, 0, 0, 1, 999, 0);
    wait_done("t_early_rlast");
    chk("t_early_rlast_beats", r_beat, 2);
    chk("t_early_rlast_err", last_err, 1);
    for (int k = 0; k < 10; k++) begin
      automatic int len = $urandom_range(0, 20);
      automatic logic wr = ($urandom & 1) != 0;
      issue(wr, $urandom, len, 1, ($urandom % 4 == 0) ? 2'b10 : 2'b00, ($urandom % 5 == 0) ? 4'h1 : 4'h0,
            ($urandom % 4 == 0) ? $urandom_range(0, len + 1) : len,
            ($urandom % 4 == 0) ? $urandom_range(0, len) : 999, ($urandom % 6 == 0) ? 4'h2 : 4'h0);
      wait_done("t_rand");
    end
    begin
      int n = 0, d0;
      issue(1, 32'h0000_2000, 5, 0, 0, 0, 0, 999, 0);
      while (w_beat < 1 && n < 200) begin @(posedge clock); #2; n++; end
      chk("t_rst_reach_w", w_beat, 1);
      d0 = done_cnt;
      reset = 0;
      @(negedge clock);
      chk("t_rst_valids", {out_wvalid, out_awvalid, out_arvalid, done_valid, req_ready}, 0);
      repeat (2) @(posedge clock);
      #2 reset = 1;
      @(negedge clock);
      chk("t_rst_req_ready", req_ready, 1);
      repeat (3) @(posedge clock);
      chk("t_rst_no_done", done_cnt, d0);
    end
    issue(0, 32'h0000_3004, 2, 1, 0, 0, 2, 999, 0);
    wait_done("t_post_rst");
    chk("t_post_rst_err", last_err, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
